render_cmd_queue: RTL and testbench

RENDER_CMD_QUEUE -- requirements
Module: render_cmd_queue

---
 rtl/render_cmd_queue.sv | 140 ++++++++++++++
 tb/tb_render_cmd_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/render_cmd_queue.sv
// Render command queue: an Avalon-MM slave stages 48-bit draw commands
// into a circular FIFO that a render engine drains via a first-word-fall-
// through head port. When the FIFO is empty the head shows an end-of-frame
// opcode so the consumer always sees a well-formed entry.
//
// Consumer handshake: render_queue_dout is valid every cycle (head entry,
// or the end-of-frame marker when empty). A pop is taken at a posedge
// where render_queue_pop_front=1 and the queue is not empty; popping an
// empty queue does nothing.
module render_cmd_queue #(
    parameter int         DEPTH           = 16,
    parameter logic [7:0] DO_RENDER_MAGIC = 8'hFF
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [47:0] render_queue_dout,
    input  logic        render_queue_pop_front
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [47:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   stage_lo_q, stage_lo_d;
    logic [31:0]   readdata_q, readdata_d;

    logic        wr_en, rd_en;
    logic        empty, full;
    logic        push_req, flush, ovf_clr;
    logic        pop_ok, push_ok, push_drop;
    logic [47:0] push_entry;
    logic [8:0]  count9;
    logic [31:0] status;

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    assign push_req   = wr_en && (address == 2'd1);
    assign flush      = wr_en && (address == 2'd3) && writedata[0];
    assign ovf_clr    = wr_en && (address == 2'd3) && writedata[1];
    assign push_entry = {writedata[15:0], stage_lo_q};

    // A pop makes room in the same cycle, so a full queue still accepts a
    // push that coincides with a valid pop.
    assign pop_ok    = render_queue_pop_front && !empty;
    assign push_ok   = push_req && (!full || pop_ok);
    assign push_drop = push_req && full && !pop_ok;

    assign count9 = 9'(count_q);
    assign status = {16'b0, count9, 4'b0, overflow_q, full, empty};

    assign render_queue_dout = empty ? {DO_RENDER_MAGIC, 40'b0} : mem_q[rd_ptr_q];
    assign readdata          = readdata_q;

    // Next-state for pointers, count, overflow, staging word and read data.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        stage_lo_d = stage_lo_q;
        readdata_d = readdata_q;

        if (wr_en && (address == 2'd0)) begin
            stage_lo_d = writedata;
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (ovf_clr) begin
            overflow_d = 1'b0;
        end else if (push_drop) begin
            overflow_d = 1'b1;
        end

        if (rd_en) begin
            case (address)
                2'd0:    readdata_d = stage_lo_q;
                2'd2:    readdata_d = status;
                default: readdata_d = 32'b0;
            endcase
        end
    end

    // Control state register with asynchronous active-high reset.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            stage_lo_q <= '0;
            readdata_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            stage_lo_q <= stage_lo_d;
            readdata_q <= readdata_d;
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk50) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_render_cmd_queue.sv
// Directed bench for render_cmd_queue: Avalon register access, FIFO
// ordering, full/overflow, empty-pop, wrap-around, flush and async reset.
module tb_render_cmd_queue;

    localparam int          DEPTH       = 16;
    localparam logic [7:0]  MAGIC       = 8'hFF;
    localparam logic [47:0] EMPTY_ENTRY = {MAGIC, 40'b0};

    logic        clk50 = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [47:0] render_queue_dout;
    logic        render_queue_pop_front;

    logic [47:0] exp_q[$];
    logic        exp_ovf;
    int          n_checks = 0;
    int          n_errors = 0;

    render_cmd_queue #(
        .DEPTH(DEPTH),
        .DO_RENDER_MAGIC(MAGIC)
    ) dut (
        .clk50(clk50),
        .reset(reset),
        .chipselect(chipselect),
        .write(write),
        .read(read),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .render_queue_dout(render_queue_dout),
        .render_queue_pop_front(render_queue_pop_front)
    );

    // Clock and reset block.
    always #10 clk50 = ~clk50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive at negedge, let one posedge pass, sample #1 later.
    task automatic bus_cycle(input logic wr, input logic rd, input logic [1:0] a,
                             input logic [31:0] d, input logic p);
        @(negedge clk50);
        chipselect             = wr | rd;
        write                  = wr;
        read                   = rd;
        address                = a;
        writedata              = d;
        render_queue_pop_front = p;
        @(posedge clk50);
        #1;
        chipselect             = 1'b0;
        write                  = 1'b0;
        read                   = 1'b0;
        render_queue_pop_front = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] v);
        bus_cycle(1'b0, 1'b1, a, 32'h0, 1'b0);
        v = readdata;
    endtask

    function automatic logic [31:0] model_status();
        logic [8:0] c;
        c = 9'(exp_q.size());
        return {16'b0, c, 4'b0, exp_ovf, (exp_q.size() == DEPTH), (exp_q.size() == 0)};
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] v;
        reg_read(2'd2, v);
        check(tag, {32'b0, v}, {32'b0, model_status()});
    endtask

    // Stage the low word, then push with the high half; upper writedata
    // bits carry junk that must be ignored.
    task automatic push_entry(input logic [47:0] e, input logic with_pop);
        bus_cycle(1'b1, 1'b0, 2'd0, e[31:0], 1'b0);
        if (with_pop && exp_q.size() > 0) begin
            check("pushpop_head", {16'b0, render_queue_dout}, {16'b0, exp_q.pop_front()});
        end
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
        bus_cycle(1'b1, 1'b0, 2'd1, {16'hDEAD, e[47:32]}, with_pop);
    endtask

    task automatic pop_one();
        if (exp_q.size() > 0) begin
            check("pop_head", {16'b0, render_queue_dout}, {16'b0, exp_q.pop_front()});
        end else begin
            check("pop_empty_head", {16'b0, render_queue_dout}, {16'b0, EMPTY_ENTRY});
        end
        bus_cycle(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    endtask

    function automatic logic [47:0] mk_entry(input int i);
        return {8'(i + 8'h10), 16'(16'h1000 + i), 16'(16'h2000 + i), 8'(i)};
    endfunction

    initial begin
        logic [31:0] v;
        reset                  = 1'b1;
        chipselect             = 1'b0;
        write                  = 1'b0;
        read                   = 1'b0;
        address                = 2'd0;
        writedata              = 32'h0;
        render_queue_pop_front = 1'b0;
        exp_ovf                = 1'b0;

        repeat (2) @(negedge clk50);
        check("reset_dout", {16'b0, render_queue_dout}, {16'b0, EMPTY_ENTRY});
        check("reset_readdata", {32'b0, readdata}, 64'h0);
        reset = 1'b0;
        reg_read(2'd2, v);
        check("reset_status", {32'b0, v}, 64'h0000_0001);

        // Single entry: stage then push.
        bus_cycle(1'b1, 1'b0, 2'd0, 32'h0064_0080, 1'b0);
        bus_cycle(1'b1, 1'b0, 2'd1, 32'h0000_0100, 1'b0);
        exp_q.push_back(48'h0100_0064_0080);
        check("first_dout", {16'b0, render_queue_dout}, 64'h0000_0100_0064_0080);
        reg_read(2'd2, v);
        check("first_status", {32'b0, v}, 64'h0000_0080);
        reg_read(2'd0, v);
        check("read_stage", {32'b0, v}, 64'h0064_0080);
        bus_cycle(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 1'b0);
        check("addr2_write_ignored_hold", {32'b0, readdata}, 64'h0064_0080);
        reg_read(2'd1, v);
        check("read_addr1", {32'b0, v}, 64'h0);
        reg_read(2'd0, v);
        check("stage_kept", {32'b0, v}, 64'h0064_0080);
        reg_read(2'd3, v);
        check("read_addr3", {32'b0, v}, 64'h0);
        check_status("after_addr2_write");
        pop_one();
        check("drained_dout", {16'b0, render_queue_dout}, {16'b0, EMPTY_ENTRY});

        // Fill to full, then overflow.
        for (int i = 0; i < DEPTH; i++) push_entry(mk_entry(i), 1'b0);
        reg_read(2'd2, v);
        check("full_status", {32'b0, v}, 64'h0000_0802);
        push_entry(mk_entry(99), 1'b0);
        reg_read(2'd2, v);
        check("overflow_status", {32'b0, v}, 64'h0000_0806);
        check("full_head", {16'b0, render_queue_dout}, {16'b0, mk_entry(0)});

        // Clear overflow only; queue contents stay.
        bus_cycle(1'b1, 1'b0, 2'd3, 32'h0000_0002, 1'b0);
        exp_ovf = 1'b0;
        reg_read(2'd2, v);
        check("ovf_cleared", {32'b0, v}, 64'h0000_0802);

        // Full queue with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            push_entry(mk_entry(40 + i), 1'b1);
            check_status("full_pushpop");
        end
        while (exp_q.size() > 0) pop_one();
        check_status("full_drained");

        // Empty pops are ignored.
        for (int i = 0; i < 3; i++) pop_one();
        check_status("empty_pops");
        // Push with pop while empty; entry carries the end-of-frame opcode.
        push_entry({MAGIC, 40'h12_3456_789A}, 1'b1);
        reg_read(2'd2, v);
        check("empty_pushpop_status", {32'b0, v}, 64'h0000_0080);
        check("magic_entry_dout", {16'b0, render_queue_dout}, {16'b0, MAGIC, 40'h12_3456_789A});
        pop_one();

        // Interleaved traffic so both pointers wrap more than once.
        for (int i = 0; i < 40; i++) begin
            push_entry(mk_entry(100 + i), 1'b0);
            if (i % 3 != 0) pop_one();
        end
        check_status("wrap_mid");
        while (exp_q.size() > 0) pop_one();
        check_status("wrap_drained");

        // Overflow, drain to 5 entries, then asynchronous reset pulse.
        for (int i = 0; i < DEPTH + 1; i++) push_entry(mk_entry(200 + i), 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) pop_one();
        check_status("five_left");
        @(negedge clk50);
        #5 reset = 1'b1;
        #2;
        check("async_reset_dout", {16'b0, render_queue_dout}, {16'b0, EMPTY_ENTRY});
        check("async_reset_readdata", {32'b0, readdata}, 64'h0);
        #2 reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        reg_read(2'd2, v);
        check("post_reset_status", {32'b0, v}, 64'h0000_0001);
        reg_read(2'd0, v);
        check("post_reset_stage", {32'b0, v}, 64'h0);

        // Flush with overflow clear, pop asserted in the same cycle.
        for (int i = 0; i < 5; i++) push_entry(mk_entry(60 + i), 1'b0);
        pop_one();
        check_status("four_entries");
        bus_cycle(1'b1, 1'b0, 2'd3, 32'h0000_0003, 1'b1);
        exp_q.delete();
        check("flush_dout", {16'b0, render_queue_dout}, {16'b0, EMPTY_ENTRY});
        check_status("flush_status");
        push_entry(mk_entry(77), 1'b0);
        check("after_flush_dout", {16'b0, render_queue_dout}, {16'b0, mk_entry(77)});
        check_status("after_flush_status");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
